// File: rtl/code_lock_ctrl_if.sv
// Keypad-to-lock bus: decoded key strobe in, lock status and pulses out.
// The keypad side drives the master modport, the controller takes the slave modport.
interface code_lock_ctrl_if #(
   parameter int CODE_LEN = 4,
   parameter int MAX_FAIL = 3
);
   localparam int DW = $clog2(CODE_LEN + 1);
   localparam int FW = $clog2(MAX_FAIL + 1);

   logic [3:0]    code;
   logic          valid;
   logic          unlock;
   logic          prog_mode;
   logic          alarm;
   logic          ok;
   logic          err;
   logic [DW-1:0] digit_cnt;
   logic [FW-1:0] fail_cnt;

   modport master (
      output code,
      output valid,
      input  unlock,
      input  prog_mode,
      input  alarm,
      input  ok,
      input  err,
      input  digit_cnt,
      input  fail_cnt
   );

   modport slave (
      input  code,
      input  valid,
      output unlock,
      output prog_mode,
      output alarm,
      output ok,
      output err,
      output digit_cnt,
      output fail_cnt
   );
endinterface

// File: rtl/code_lock_ctrl.sv
// Code-lock controller: digit entry, re-programming, fail lockout and
// timed auto-relock driven from decoded keypad strobes.
module code_lock_ctrl #(
   parameter int CODE_LEN = 4,
   parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 16'h1234,
   parameter int MAX_FAIL = 3,
   parameter int UNLOCK_CYCLES = 100000,
   parameter int LOCKOUT_CYCLES = 500000,
   parameter int ENTRY_TIMEOUT = 200000
) (
   input logic             clock,
   input logic             reset,
   code_lock_ctrl_if.slave bus
);
   localparam int BW = CODE_LEN * 4;
   localparam int DW = $clog2(CODE_LEN + 1);
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam int MAX_UL =
      (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int MAX_T =
      (MAX_UL > ENTRY_TIMEOUT) ? MAX_UL : ENTRY_TIMEOUT;
   localparam int TW = $clog2(MAX_T + 1);

   // Loaded as P-1 so a window entered at cycle s ends exactly at s+P.
   localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY_TIMEOUT - 1);
   localparam logic [DW-1:0] FULL = DW'(CODE_LEN);
   localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

   typedef enum logic [2:0] {
      S_LOCKED,
      S_ENTRY,
      S_UNLOCKED,
      S_PROG,
      S_LOCKOUT
   } state_t;

   state_t        state;
   state_t        state_d;
   logic [BW-1:0] entry;
   logic [BW-1:0] entry_d;
   logic [BW-1:0] stored;
   logic [BW-1:0] stored_d;
   logic [DW-1:0] cnt;
   logic [DW-1:0] cnt_d;
   logic          ovf;
   logic          ovf_d;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_d;
   logic [FW-1:0] fail;
   logic [FW-1:0] fail_d;

   logic unlock_q;
   logic unlock_d;
   logic prog_q;
   logic prog_d;
   logic alarm_q;
   logic alarm_d;
   logic ok_q;
   logic ok_d;
   logic err_q;
   logic err_d;

   logic          is_digit;
   logic          is_star;
   logic          is_hash;
   logic          expired;
   logic          entry_ok;
   logic          match;
   logic [BW-1:0] shifted;
   logic [FW-1:0] fail_inc;

   assign is_digit = bus.valid && (bus.code <= 4'd9);
   assign is_star  = bus.valid && (bus.code == 4'd10);
   assign is_hash  = bus.valid && (bus.code == 4'd11);
   assign expired  = (timer == '0);
   assign entry_ok = (cnt == FULL) && !ovf;
   assign match    = entry_ok && (entry == stored);
   assign fail_inc = fail + 1'b1;

   generate
      if (CODE_LEN > 1) begin : g_shift
         assign shifted = {entry[BW-5:0], bus.code};
      end else begin : g_single
         assign shifted = bus.code;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= S_LOCKED;
         entry    <= '0;
         stored   <= DEFAULT_CODE;
         cnt      <= '0;
         ovf      <= 1'b0;
         timer    <= '0;
         fail     <= '0;
         unlock_q <= 1'b0;
         prog_q   <= 1'b0;
         alarm_q  <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_d;
         entry    <= entry_d;
         stored   <= stored_d;
         cnt      <= cnt_d;
         ovf      <= ovf_d;
         timer    <= timer_d;
         fail     <= fail_d;
         unlock_q <= unlock_d;
         prog_q   <= prog_d;
         alarm_q  <= alarm_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state;
      entry_d  = entry;
      stored_d = stored;
      cnt_d    = cnt;
      ovf_d    = ovf;
      fail_d   = fail;
      timer_d  = expired ? timer : timer - 1'b1;

      unique case (state)
         S_LOCKED: begin
            if (is_digit) begin
               entry_d = shifted;
               cnt_d   = DW'(1);
               ovf_d   = 1'b0;
               timer_d = T_ENTRY;
               state_d = S_ENTRY;
            end
         end

         S_ENTRY, S_PROG: begin
            unique case (1'b1)
               is_digit: begin
                  if (cnt == FULL) begin
                     ovf_d = 1'b1;
                  end else begin
                     entry_d = shifted;
                     cnt_d   = cnt + 1'b1;
                  end
                  timer_d = T_ENTRY;
               end
               is_star: begin
                  entry_d = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  if (state == S_PROG) begin
                     timer_d = T_UNLOCK;
                     state_d = S_UNLOCKED;
                  end else begin
                     state_d = S_LOCKED;
                  end
               end
               is_hash: begin
                  entry_d = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  if (state == S_PROG) begin
                     if (entry_ok) begin
                        stored_d = entry;
                        state_d  = S_LOCKED;
                     end else begin
                        timer_d = T_UNLOCK;
                        state_d = S_UNLOCKED;
                     end
                  end else if (match) begin
                     fail_d  = '0;
                     timer_d = T_UNLOCK;
                     state_d = S_UNLOCKED;
                  end else begin
                     fail_d = fail_inc;
                     if (fail_inc == FAIL_MAX) begin
                        timer_d = T_LOCKOUT;
                        state_d = S_LOCKOUT;
                     end else begin
                        state_d = S_LOCKED;
                     end
                  end
               end
               default: begin
                  if (expired) begin
                     entry_d = '0;
                     cnt_d   = '0;
                     ovf_d   = 1'b0;
                     state_d = S_LOCKED;
                  end
               end
            endcase
         end

         // Expiry outranks any key arriving on the same cycle.
         S_UNLOCKED: begin
            if (expired || is_hash) begin
               state_d = S_LOCKED;
            end else if (is_star) begin
               entry_d = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               timer_d = T_ENTRY;
               state_d = S_PROG;
            end
         end

         S_LOCKOUT: begin
            if (expired) begin
               fail_d  = '0;
               state_d = S_LOCKED;
            end
         end

         default: begin
            state_d = S_LOCKED;
         end
      endcase
   end

   always_comb begin
      unlock_d = (state_d == S_UNLOCKED) || (state_d == S_PROG);
      prog_d   = (state_d == S_PROG);
      alarm_d  = (state_d == S_LOCKOUT);
      ok_d     = 1'b0;
      err_d    = 1'b0;
      if (is_hash) begin
         unique case (state)
            S_ENTRY: begin
               ok_d  = match;
               err_d = !match;
            end
            S_PROG: begin
               ok_d  = entry_ok;
               err_d = !entry_ok;
            end
            default: begin
               ok_d  = 1'b0;
               err_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.unlock    = unlock_q;
   assign bus.prog_mode = prog_q;
   assign bus.alarm     = alarm_q;
   assign bus.ok        = ok_q;
   assign bus.err       = err_q;
   assign bus.digit_cnt = cnt;
   assign bus.fail_cnt  = fail;
endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Parametrised code-lock controller that consumes decoded keypresses (`code`/`valid`) from the keypad scanner and decides lock state. It is the successor to the fixed-function decider, adding:
- a configurable code length and a default code;
- a user re-programming mode;
- an entry inactivity timeout;
- a failed-attempt counter with timed lockout/alarm;
- a timed auto-relock.

It sits directly after the keypad scanner/synchronizer chain and drives the lock actuator and alarm.

## Interface
- `CODE_LEN`, 4: digits per code (1..8).
- `DEFAULT_CODE`, `16'h1234`: `CODE_LEN*4` bits, BCD, first digit in MS nibble; loaded at reset.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (≥1).
- `UNLOCK_CYCLES`, 100000: cycles unlock stays asserted.
- `LOCKOUT_CYCLES`, 500000: cycles of lockout.
- `ENTRY_TIMEOUT`, 200000: idle cycles before a partial entry is discarded.
- `clock` input 1: the single clock. All logic is on its rising edge.
- `reset` input 1: synchronous, active-low.
- `code` input 4: key code. 0-9 are digits, 10 is `*`, 11 is `#`, 12-15 are ignored.
- `valid` input 1: one-cycle strobe, one per keypress; `code` is sampled only when it is high.
- `unlock` output 1: high while in UNLOCKED or PROG.
- `prog_mode` output 1: high in PROG.
- `alarm` output 1: high in LOCKOUT.
- `ok` output 1: one-cycle pulse on a successful unlock or a successful re-program.
- `err` output 1: one-cycle pulse on a rejected entry.
- `digit_cnt` output `$clog2(CODE_LEN+1)`: digits currently buffered (saturating).
- `fail_cnt` output `$clog2(MAX_FAIL+1)`: consecutive failures.

## Operation
- **Shared datapath.** One entry buffer (`CODE_LEN*4` bits), `digit_cnt`, an overflow flag, one down-counter timer sized to the largest timing parameter, and the stored-code register.
- **Digit entry.** A digit shifts in as `buf <= {buf[N*4-5:0], code}`.
  - If `digit_cnt == CODE_LEN`, the buffer is not shifted, the overflow flag is set, and the count saturates.
- **Valid entry.** An entry is valid iff `digit_cnt == CODE_LEN` and overflow is clear.
- **States.**
  - **LOCKED**
    - Digit: buffer it, `digit_cnt=1`, load the entry timer, go to ENTRY.
    - `*` / `#` / codes 12-15: ignored.
  - **ENTRY**
    - Digit: buffer it and reload the entry timer.
    - `*`: clear the entry and go to LOCKED. No failure is counted.
    - Timer expiry with no keypress: same as `*`.
    - `#` with a valid entry and `buf == stored`: `ok` pulse, `fail_cnt=0`, load `UNLOCK_CYCLES`, go to UNLOCKED.
    - Any other `#`: `err` pulse and `fail_cnt+1`.
      - If the new count equals `MAX_FAIL`: load `LOCKOUT_CYCLES`, go to LOCKOUT.
      - Otherwise go to LOCKED.
    - Every exit from ENTRY clears the buffer, count and overflow.
  - **UNLOCKED**
    - Timer expiry: go to LOCKED.
    - `#`: go to LOCKED immediately (manual relock).
    - `*`: clear the buffer, load the entry timer, go to PROG.
    - Digits: ignored, and they do not extend the timer.
  - **PROG**
    - Digit: handled as in ENTRY, reloading the entry timer.
    - `#` with a valid entry: `stored <= buf`, `ok` pulse, go to LOCKED.
    - `#` with an invalid entry: `err` pulse, `stored` unchanged, reload `UNLOCK_CYCLES`, go to UNLOCKED. `fail_cnt` is unaffected.
    - `*`: abort, reload `UNLOCK_CYCLES`, go to UNLOCKED.
    - Entry-timer expiry: abort to LOCKED.
  - **LOCKOUT**
    - All keys are ignored.
    - Timer expiry: `fail_cnt=0`, go to LOCKED.
- **Reset.**
  - State LOCKED; `stored=DEFAULT_CODE`; buffer, counts and timer are 0.
  - All outputs are 0.
  - Reset mid-operation aborts everything, and a programmed code is lost.

## Timing
- All outputs are registered. A keypress on `valid` in cycle t takes effect, with its outputs, in cycle t+1.
- `ok` and `err` are high for exactly one cycle, in that t+1 cycle.
- **Timed windows.** A timed state entered at cycle s, with no intervening key, exits at cycle s+P, where P is the loaded parameter.
  - This gives `unlock` exactly `UNLOCK_CYCLES` cycles high.
  - It gives `alarm` exactly `LOCKOUT_CYCLES` cycles high.
- **Entry timeout.** The timeout fires `ENTRY_TIMEOUT` cycles after the last accepted keypress.
- **Simultaneous events.**
  - In UNLOCKED, timer expiry and a key in the same cycle: expiry wins and the key is dropped.
  - In ENTRY/PROG, a keypress and expiry in the same cycle: the key wins, and the timer is reloaded.
- **Back-to-back strobes.** `valid` may be high on consecutive cycles, and every strobe is processed. There is no back-pressure.

## Test plan
Bench parameters: `UNLOCK_CYCLES=100`, `LOCKOUT_CYCLES=200`, `ENTRY_TIMEOUT=50`, other parameters at their defaults.

- **Reset defaults:** hold `reset=0` for 3 cycles → all outputs 0. Then 1,2,3,4,`#` → `ok` pulse, `unlock` high for exactly 100 cycles, then LOCKED.
- **Lockout:** three entries of 1,2,3,5,`#` → `err` ×3, `fail_cnt` 1→2→3, `alarm` high for 200 cycles with keys ignored, then `fail_cnt=0`. A correct code afterwards unlocks.
- **Length rules:** 1,2,3,`#` → `err`. 1,2,3,4,5,`#` → `err` (overflow). 1,2,`*`,1,2,3,4,`#` → `ok`, `fail_cnt` 0.
- **Re-program:** unlock, then `*`,9,8,7,6,`#` → `ok`, LOCKED. 1,2,3,4,`#` → `err`. 9,8,7,6,`#` → unlock. Then assert reset → code reverts to 1234.
- **Timeouts/aborts:** enter 1,2 and wait 50 cycles → `digit_cnt=0`, no `err`. In PROG enter 9,9 then `#` → `err`, back to UNLOCKED with a 100-cycle reload, code unchanged.
- **Simultaneous/relock:** `*` on the expiry cycle of UNLOCKED → LOCKED, not PROG. `#` in UNLOCKED → `unlock` drops the next cycle. Back-to-back `valid` 1,2,3,4,`#` on 5 consecutive cycles → unlock.
